sprite_ram_dma: RTL and testbench
=================================

# sprite_ram_dma

Writer side of the sprite attribute RAM that `sprite_engine` reads. The CPU fills a 128-byte shadow table in work RAM and arms a transfer. On the next vblank rising edge, the block requests the work RAM bus. It then copies the table into sprite RAM at one byte per clock, so sprite data never changes while a frame is being drawn. It sits between the CPU register decode, the work RAM arbiter and the sprite RAM write port.

## Interface
- `TABLE_BYTES`, 128: bytes per transfer. 32 sprites × 4 bytes.
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-low
- `vblank`  in  1  video vertical blank
- `cpu_wr`  in  1  register write strobe, one cycle
- `cpu_rd`  in  1  register read strobe, one cycle
- `cpu_addr`  in  2  register select: 0 src_lo, 1 src_hi, 2 control, 3 status
- `cpu_din`  in  8  register write data
- `cpu_dout`  out  8  register read data, combinational from `cpu_addr`
- `dma_req`  out  1  work RAM bus request
- `dma_ack`  in  1  bus granted, CPU held off
- `src_addr`  out  16  work RAM read address
- `src_data`  in  8  work RAM read data, valid one cycle after `src_addr`
- `spriteram_wr_addr`  out  7  sprite RAM write address
- `spriteram_data_in`  out  8  sprite RAM write data
- `spriteram_wr`  out  1  sprite RAM write enable

## Operation
- Sprite RAM byte layout per sprite n, at base 4n, is passed through unmodified:
  - +0: [7] enable, [3:0] Y[11:8]
  - +1: Y[7:0]
  - +2: [7:2] image, [1:0] X[9:8]
  - +3: X[7:0]
- Registers:
  - src_lo and src_hi are read/write. They hold the 16-bit source base.
  - control write: bit0 = arm, bit1 = immediate (skip the vblank wait). Control reads as 0.
  - status: bit0 busy, bit1 pending, bit2 done, bit3 late. Bits 2 and 3 are sticky and clear on a `cpu_rd` of status.
- Source base is latched into a working register when COPY is entered. CPU writes to src_lo/src_hi during a transfer affect only the next transfer.
- State machine:
  - IDLE: an arm write goes to ARMED. If immediate is also set, it goes to REQ directly.
  - ARMED: a vblank rising edge (vblank=1, previous=0) goes to REQ. If vblank is already high when armed, wait for the next rising edge.
  - REQ: `dma_req`=1. Go to COPY when `dma_ack`=1.
  - COPY: issue `src_addr` = base + count, then count++. After count reaches 127 and that read is issued, go to DRAIN.
  - DRAIN: write the last byte, drop `dma_req`, set done, then go to IDLE. If pending is set, go to ARMED instead and clear pending.
- busy = state ≠ IDLE.
- An arm write while busy sets pending, which queues exactly one further transfer. Arm writes beyond that are absorbed.
- late is set if vblank falls while in REQ, COPY or DRAIN. The transfer still completes.
- If `dma_ack` deasserts during COPY, no new read is issued and count holds. The read already in flight is still written. Issuing resumes when ack returns.
- Address arithmetic: `src_addr` = base + count, modulo 2^16, so 0xFFFF wraps to 0x0000. `spriteram_wr_addr` = count of the issued read, 7 bits, delayed one cycle.

## Timing
- Reset (reset=0 at a clk edge) sets:
  - state to IDLE
  - `dma_req`, `spriteram_wr`, `spriteram_wr_addr` and `spriteram_data_in` to 0
  - src_lo and src_hi to 0
  - all status bits to 0
- A reset mid-transfer abandons it immediately. `dma_req` and `spriteram_wr` are 0 on the next cycle, and sprite RAM may be partially updated.
- Read pipeline: `src_addr` is issued in cycle k. In cycle k+1, `spriteram_wr`=1, `spriteram_data_in`=`src_data` and `spriteram_wr_addr`=the index issued in k.
- With continuous ack, a transfer takes 1 (REQ→COPY) + 128 + 1 (DRAIN) cycles from ack to `dma_req` low.
- Vblank-edge detection adds 1 cycle from the vblank rise to `dma_req`.
- Simultaneous events in one cycle:
  - status read and done being set: done ends up set.
  - arm write and DRAIN completion: pending is set, then ARMED.

## Structure
- A shared package `comet_pkg` holds:
  - sprite RAM constants: `SPR_COUNT`=32, `SPR_ITEM_BYTES`=4, and the byte-offset and bitfield positions above.
  - register offsets and status bit indices.
- One sub-module: `vblank_edge`, a registered rising/falling edge detector, also reusable in `sprite_engine` for hsync.

## Test plan
- Arm with src=0x8000 holding pattern i, ack tied high, vblank pulse → `dma_req` 1 cycle after the vblank rise. Sprite RAM[i]=i for i=0..127, done=1, busy=0. A status read returns 0x04, then 0x00.
- Arm while vblank is already high → no `dma_req` until vblank falls and rises again.
- src=0xFFC0 with immediate arm → reads run 0xFFC0..0xFFFF then 0x0000..0x003F. Sprite RAM[64] comes from address 0x0000.
- Deassert ack for 5 cycles at count 40 → index 40's write still occurs. Total writes = 128 with no duplicates, and the transfer takes 5 extra cycles.
- Arm twice during COPY → pending=1, exactly one more transfer follows on the next vblank rise, then IDLE.
- Assert reset at count 60 → next cycle `dma_req`=0, `spriteram_wr`=0, status=0x00, and no further writes.

Source files
------------

// File: rtl/comet_pkg.sv
// Shared sprite-subsystem constants: sprite RAM byte layout, the DMA register map
// and the DMA state encoding.
package comet_pkg;

  localparam int TABLE_BYTES    = 128;
  localparam int SPR_COUNT      = 32;
  localparam int SPR_ITEM_BYTES = 4;

  // Byte offsets inside one 4-byte sprite record and the bitfields they carry.
  localparam int SPR_OFS_ATTR = 0;
  localparam int SPR_OFS_YLO  = 1;
  localparam int SPR_OFS_IMG  = 2;
  localparam int SPR_OFS_XLO  = 3;
  localparam int SPR_EN_BIT   = 7;
  localparam int SPR_YHI_MSB  = 3;
  localparam int SPR_YHI_LSB  = 0;
  localparam int SPR_IMG_MSB  = 7;
  localparam int SPR_IMG_LSB  = 2;
  localparam int SPR_XHI_MSB  = 1;
  localparam int SPR_XHI_LSB  = 0;

  localparam logic [1:0] REG_SRC_LO = 2'd0;
  localparam logic [1:0] REG_SRC_HI = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_ARM_BIT = 0;
  localparam int CTRL_IMM_BIT = 1;

  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_PENDING_BIT = 1;
  localparam int STAT_DONE_BIT    = 2;
  localparam int STAT_LATE_BIT    = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_REQ   = 3'd2,
    ST_COPY  = 3'd3,
    ST_DRAIN = 3'd4
  } dma_state_t;

  function automatic logic [7:0] pack_status(input logic busy, input logic pending,
                                             input logic done, input logic late);
    logic [7:0] s;
    s                   = 8'h00;
    s[STAT_BUSY_BIT]    = busy;
    s[STAT_PENDING_BIT] = pending;
    s[STAT_DONE_BIT]    = done;
    s[STAT_LATE_BIT]    = late;
    return s;
  endfunction

endpackage

// File: rtl/sprite_ram_dma_if.sv
// Signal bundle of the sprite RAM DMA: CPU register port, work RAM bus, sprite RAM
// write port and vblank. master = the DMA block, slave = the surrounding system.
interface sprite_ram_dma_if;
  logic       vblank;
  logic       cpu_wr;
  logic       cpu_rd;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic       dma_req;
  logic       dma_ack;
  logic [15:0] src_addr;
  logic [7:0] src_data;
  logic [6:0] spriteram_wr_addr;
  logic [7:0] spriteram_data_in;
  logic       spriteram_wr;

  modport master (
    input  vblank, cpu_wr, cpu_rd, cpu_addr, cpu_din, dma_ack, src_data,
    output cpu_dout, dma_req, src_addr, spriteram_wr_addr, spriteram_data_in, spriteram_wr
  );

  modport slave (
    output vblank, cpu_wr, cpu_rd, cpu_addr, cpu_din, dma_ack, src_data,
    input  cpu_dout, dma_req, src_addr, spriteram_wr_addr, spriteram_data_in, spriteram_wr
  );
endinterface

// File: rtl/sprite_ram_dma_vblank_edge.sv
// Edge detector on a level signal; keeps last cycle's level in a register and flags
// rising/falling transitions in the cycle the new level is first seen.
module vblank_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise,
  output logic fall
);
  logic prev_r;

  // Previous-cycle copy of the monitored level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= level;
    end
  end

  assign rise = level & ~prev_r;
  assign fall = ~level & prev_r;
endmodule

// File: rtl/sprite_ram_dma.sv
// Copies the 128-byte sprite shadow table from work RAM into sprite RAM, one byte per
// clock, once armed by the CPU and (unless immediate) on the next vblank rising edge.
module sprite_ram_dma
  import comet_pkg::*;
(
  input logic              clk,
  input logic              reset,
  sprite_ram_dma_if.master bus
);
  localparam logic [6:0] LAST_IDX = 7'(TABLE_BYTES - 1);

  dma_state_t  state_r;
  logic [6:0]  count_r;
  logic [15:0] src_addr_r;
  logic [7:0]  src_lo_r;
  logic [7:0]  src_hi_r;
  logic        dma_req_r;
  logic        wr_r;
  logic [6:0]  wr_addr_r;
  logic        pending_r;
  logic        done_r;
  logic        late_r;

  logic        rise_s;
  logic        fall_s;
  logic        arm_s;
  logic        imm_s;
  logic        stat_rd_s;
  logic        busy_s;
  logic        issue_s;
  logic        in_xfer_s;
  logic [7:0]  cpu_dout_s;

  vblank_edge u_vblank_edge (
    .clk   (clk),
    .reset (reset),
    .level (bus.vblank),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  assign arm_s     = bus.cpu_wr && (bus.cpu_addr == REG_CTRL) && bus.cpu_din[CTRL_ARM_BIT];
  assign imm_s     = bus.cpu_din[CTRL_IMM_BIT];
  assign stat_rd_s = bus.cpu_rd && (bus.cpu_addr == REG_STATUS);
  assign busy_s    = (state_r != ST_IDLE);
  assign issue_s   = (state_r == ST_COPY) && bus.dma_ack;
  assign in_xfer_s = (state_r == ST_REQ) || (state_r == ST_COPY) || (state_r == ST_DRAIN);

  // Transfer sequencer; src_addr_r is the working copy of base + count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      dma_req_r  <= 1'b0;
      count_r    <= 7'd0;
      src_addr_r <= 16'h0000;
      pending_r  <= 1'b0;
    end else begin
      // Only one further transfer can be queued; extra arms are absorbed.
      if (arm_s && busy_s) begin
        pending_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (arm_s) begin
            if (imm_s) begin
              state_r   <= ST_REQ;
              dma_req_r <= 1'b1;
            end else begin
              state_r <= ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          if (rise_s) begin
            state_r   <= ST_REQ;
            dma_req_r <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus.dma_ack) begin
            state_r    <= ST_COPY;
            count_r    <= 7'd0;
            src_addr_r <= {src_hi_r, src_lo_r};
          end
        end
        ST_COPY: begin
          if (issue_s) begin
            count_r    <= count_r + 7'd1;
            src_addr_r <= src_addr_r + 16'd1;
            if (count_r == LAST_IDX) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // An arm landing on this same cycle counts as the queued transfer.
          dma_req_r <= 1'b0;
          pending_r <= 1'b0;
          state_r   <= (pending_r || arm_s) ? ST_ARMED : ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          dma_req_r <= 1'b0;
          pending_r <= 1'b0;
        end
      endcase
    end
  end

  // Sprite RAM write stage, one cycle behind the issued read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_r      <= 1'b0;
      wr_addr_r <= 7'd0;
    end else begin
      wr_r <= issue_s;
      if (issue_s) begin
        wr_addr_r <= count_r;
      end
    end
  end

  // CPU-visible source registers and sticky status; a set beats a clearing read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      src_lo_r <= 8'h00;
      src_hi_r <= 8'h00;
      done_r   <= 1'b0;
      late_r   <= 1'b0;
    end else begin
      if (bus.cpu_wr && (bus.cpu_addr == REG_SRC_LO)) begin
        src_lo_r <= bus.cpu_din;
      end
      if (bus.cpu_wr && (bus.cpu_addr == REG_SRC_HI)) begin
        src_hi_r <= bus.cpu_din;
      end
      done_r <= (state_r == ST_DRAIN) || (done_r && !stat_rd_s);
      late_r <= (fall_s && in_xfer_s) || (late_r && !stat_rd_s);
    end
  end

  // Register read mux.
  always_comb begin
    cpu_dout_s = 8'h00;
    case (bus.cpu_addr)
      REG_SRC_LO: cpu_dout_s = src_lo_r;
      REG_SRC_HI: cpu_dout_s = src_hi_r;
      REG_CTRL:   cpu_dout_s = 8'h00;
      REG_STATUS: cpu_dout_s = pack_status(busy_s, pending_r, done_r, late_r);
      default:    cpu_dout_s = 8'h00;
    endcase
  end

  assign bus.cpu_dout          = cpu_dout_s;
  assign bus.dma_req           = dma_req_r;
  assign bus.src_addr          = src_addr_r;
  assign bus.spriteram_wr      = wr_r;
  assign bus.spriteram_wr_addr = wr_addr_r;
  assign bus.spriteram_data_in = wr_r ? bus.src_data : 8'h00;
endmodule

// File: tb/tb_sprite_ram_dma.sv
// Directed bench for sprite_ram_dma: register vector table plus hand-written transfer
// sequences against a work RAM model and a sprite RAM write recorder.
module tb_sprite_ram_dma;
  import comet_pkg::*;

  typedef struct {
    logic       is_write;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
  } reg_vec_t;

  logic clk = 1'b0;
  logic reset;
  logic clr;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] wram [0:65535];
  logic [7:0] sram [0:127];
  int         wcnt [0:127];
  int         total_wr;

  sprite_ram_dma_if bus ();

  sprite_ram_dma dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Work RAM: synchronous read, data valid the cycle after the address.
  always @(posedge clk) bus.src_data <= wram[bus.src_addr];

  // Sprite RAM recorder: contents plus a per-address write count.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 128; i++) begin
        sram[i] <= 8'hEE;
        wcnt[i] <= 0;
      end
      total_wr <= 0;
    end else if (bus.spriteram_wr) begin
      sram[bus.spriteram_wr_addr] <= bus.spriteram_data_in;
      wcnt[bus.spriteram_wr_addr] <= wcnt[bus.spriteram_wr_addr] + 1;
      total_wr <= total_wr + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    bus.cpu_wr   = 1'b1;
    bus.cpu_addr = a;
    bus.cpu_din  = d;
    @(negedge clk);
    bus.cpu_wr   = 1'b0;
    bus.cpu_addr = REG_STATUS;
  endtask

  task automatic status_read(input string nm, input logic [7:0] exp);
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = REG_STATUS;
    #1;
    chk(nm, bus.cpu_dout, exp);
    @(negedge clk);
    bus.cpu_rd = 1'b0;
  endtask

  task automatic peek_status(input string nm, input logic [7:0] exp);
    bus.cpu_addr = REG_STATUS;
    #1;
    chk(nm, bus.cpu_dout, exp);
  endtask

  task automatic clear_model();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic wait_req_low(input string nm, input int maxc, output int hi);
    hi = 0;
    while (bus.dma_req === 1'b1 && hi < maxc) begin
      hi++;
      @(negedge clk);
    end
    chk({nm, "_timeout"}, 32'(hi < maxc), 32'd1);
  endtask

  task automatic check_table(input string nm, input logic [15:0] base, input int n);
    int bad;
    logic [15:0] a;
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      a = base + 16'(i);
      if (sram[i] !== wram[a] || wcnt[i] != n) bad++;
    end
    chk(nm, bad, 0);
  endtask

  reg_vec_t vecs [14];
  int hi;
  int hold;
  int seen;
  int snap;
  logic dropped;
  logic [15:0] wa;

  initial begin
    vecs[0]  = '{1'b0, REG_SRC_LO, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, REG_SRC_HI, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, REG_CTRL,   8'h00, 8'h00};
    vecs[3]  = '{1'b0, REG_STATUS, 8'h00, 8'h00};
    vecs[4]  = '{1'b1, REG_SRC_LO, 8'h5A, 8'h00};
    vecs[5]  = '{1'b1, REG_SRC_HI, 8'hC3, 8'h00};
    vecs[6]  = '{1'b0, REG_SRC_LO, 8'h00, 8'h5A};
    vecs[7]  = '{1'b0, REG_SRC_HI, 8'h00, 8'hC3};
    vecs[8]  = '{1'b1, REG_CTRL,   8'h00, 8'h00};
    vecs[9]  = '{1'b0, REG_CTRL,   8'h00, 8'h00};
    vecs[10] = '{1'b0, REG_STATUS, 8'h00, 8'h00};
    vecs[11] = '{1'b1, REG_SRC_LO, 8'hFF, 8'h00};
    vecs[12] = '{1'b0, REG_SRC_LO, 8'h00, 8'hFF};
    vecs[13] = '{1'b0, REG_SRC_HI, 8'h00, 8'hC3};

    for (int i = 0; i < 65536; i++) wram[i] = 8'h00;
    for (int i = 0; i < 128; i++) begin
      wram[16'h8000 + 16'(i)] = 8'(i);
      wa = 16'hFFC0 + 16'(i);
      wram[wa] = 8'(i) ^ 8'hA5;
    end

    reset = 1'b0; clr = 1'b0;
    bus.vblank = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0;
    bus.cpu_addr = 2'd0; bus.cpu_din = 8'h00; bus.dma_ack = 1'b1;
    repeat (3) @(negedge clk);
    clear_model();
    reset = 1'b1;
    #1;
    chk("rst_dma_req", bus.dma_req, 1'b0);
    chk("rst_wr", bus.spriteram_wr, 1'b0);
    chk("rst_wr_addr", bus.spriteram_wr_addr, 7'd0);
    chk("rst_data_in", bus.spriteram_data_in, 8'h00);
    @(negedge clk);

    // Register map vectors.
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_write) begin
        cpu_write(vecs[i].addr, vecs[i].din);
      end else begin
        bus.cpu_addr = vecs[i].addr;
        #1;
        chk($sformatf("reg_vec%0d", i), bus.cpu_dout, vecs[i].exp);
        @(negedge clk);
      end
    end

    // S1: vblank-triggered transfer from 0x8000.
    clear_model();
    cpu_write(REG_SRC_LO, 8'h00);
    cpu_write(REG_SRC_HI, 8'h80);
    cpu_write(REG_CTRL, 8'h01);
    peek_status("s1_armed_status", 8'h01);
    bus.vblank = 1'b1;
    #1;
    chk("s1_req_before_edge", bus.dma_req, 1'b0);
    @(negedge clk);
    chk("s1_req_after_edge", bus.dma_req, 1'b1);
    wait_req_low("s1_req", 400, hi);
    chk("s1_req_cycles", hi, 130);
    check_table("s1_table", 16'h8000, 1);
    chk("s1_sram0", sram[0], 8'h00);
    chk("s1_sram127", sram[127], 8'h7F);
    bus.vblank = 1'b0;
    @(negedge clk);
    status_read("s1_status_done", 8'h04);
    status_read("s1_status_clr", 8'h00);

    // S2: arm while vblank already high waits for the next rise.
    clear_model();
    bus.vblank = 1'b1;
    repeat (3) @(negedge clk);
    cpu_write(REG_CTRL, 8'h01);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.dma_req) seen++;
    end
    chk("s2_no_req_high", seen, 0);
    bus.vblank = 1'b0;
    repeat (3) @(negedge clk);
    chk("s2_no_req_low", bus.dma_req, 1'b0);
    bus.vblank = 1'b1;
    #1;
    chk("s2_req_before_edge", bus.dma_req, 1'b0);
    @(negedge clk);
    chk("s2_req_after_edge", bus.dma_req, 1'b1);
    wait_req_low("s2_req", 400, hi);
    check_table("s2_table", 16'h8000, 1);
    status_read("s2_status", 8'h04);
    bus.vblank = 1'b0;
    @(negedge clk);

    // S3: immediate arm, source wraps past 0xFFFF.
    clear_model();
    cpu_write(REG_SRC_LO, 8'hC0);
    cpu_write(REG_SRC_HI, 8'hFF);
    cpu_write(REG_CTRL, 8'h03);
    chk("s3_req_immediate", bus.dma_req, 1'b1);
    wait_req_low("s3_req", 400, hi);
    chk("s3_req_cycles", hi, 130);
    check_table("s3_table", 16'hFFC0, 1);
    chk("s3_sram63", sram[63], 8'h9A);
    chk("s3_sram64", sram[64], 8'hE5);
    status_read("s3_status", 8'h04);

    // S4: ack dropped for 5 cycles mid-copy.
    clear_model();
    cpu_write(REG_SRC_LO, 8'h00);
    cpu_write(REG_SRC_HI, 8'h80);
    cpu_write(REG_CTRL, 8'h03);
    hi = 0; hold = 0; dropped = 1'b0;
    while (bus.dma_req === 1'b1 && hi < 400) begin
      hi++;
      if (hold > 0) begin
        if (hold == 5) chk("s4_no_write_in_gap", bus.spriteram_wr, 1'b0);
        hold--;
        if (hold == 0) bus.dma_ack = 1'b1;
      end else if (!dropped && bus.spriteram_wr && bus.spriteram_wr_addr == 7'd40) begin
        dropped = 1'b1;
        bus.dma_ack = 1'b0;
        hold = 5;
      end
      @(negedge clk);
    end
    bus.dma_ack = 1'b1;
    chk("s4_ack_dropped", dropped, 1'b1);
    chk("s4_req_cycles", hi, 135);
    chk("s4_total_writes", total_wr, 128);
    check_table("s4_table", 16'h8000, 1);
    status_read("s4_status", 8'h04);

    // S5: two arms during copy queue exactly one vblank-gated transfer; late flag.
    clear_model();
    cpu_write(REG_CTRL, 8'h03);
    repeat (10) @(negedge clk);
    cpu_write(REG_CTRL, 8'h01);
    cpu_write(REG_CTRL, 8'h01);
    peek_status("s5_pending_status", 8'h03);
    wait_req_low("s5_first", 400, hi);
    peek_status("s5_rearmed_status", 8'h05);
    repeat (5) @(negedge clk);
    chk("s5_waits_vblank", bus.dma_req, 1'b0);
    bus.vblank = 1'b1;
    @(negedge clk);
    chk("s5_second_req", bus.dma_req, 1'b1);
    repeat (20) @(negedge clk);
    bus.vblank = 1'b0;
    wait_req_low("s5_second", 400, hi);
    peek_status("s5_final_status", 8'h0C);
    repeat (10) @(negedge clk);
    chk("s5_no_third", bus.dma_req, 1'b0);
    chk("s5_total_writes", total_wr, 256);
    check_table("s5_table", 16'h8000, 2);
    status_read("s5_status_read", 8'h0C);
    status_read("s5_status_clr", 8'h00);

    // S6: reset in the middle of a copy.
    clear_model();
    cpu_write(REG_CTRL, 8'h03);
    hi = 0;
    while (!(bus.spriteram_wr && bus.spriteram_wr_addr == 7'd59) && hi < 300) begin
      hi++;
      @(negedge clk);
    end
    chk("s6_reach_60_timeout", 32'(hi < 300), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("s6_req_cleared", bus.dma_req, 1'b0);
    chk("s6_wr_cleared", bus.spriteram_wr, 1'b0);
    peek_status("s6_status", 8'h00);
    bus.cpu_addr = REG_SRC_HI;
    #1;
    chk("s6_src_hi_cleared", bus.cpu_dout, 8'h00);
    reset = 1'b1;
    snap = total_wr;
    chk("s6_writes_before", snap, 60);
    repeat (20) @(negedge clk);
    chk("s6_no_more_writes", total_wr, snap);
    chk("s6_req_stays_low", bus.dma_req, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
